// File: rtl/axi_lite_rd_sram.sv
// AXI-lite read-only (AR/R) responder backed by a word-addressed SRAM, with a programmable
// read latency and a side-band preload write port that works in every state.
module axi_lite_rd_sram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slv_ar_valid_i,
  input  logic [31:0] slv_ar_addr_i,
  output logic        slv_ar_ready_o,
  output logic        slv_r_valid_o,
  output logic [31:0] slv_r_data_o,
  output logic [1:0]  slv_r_resp_o,
  input  logic        slv_r_ready_i,
  input  logic        ld_en_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_data_i
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] SPAN    = 32'(DEPTH) * 32'd4;
  localparam logic [3:0]  LAT_CNT = 4'(LATENCY);
  localparam logic        LAT_EN  = (LATENCY != 32'd0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  if (LATENCY > 32'd15) begin : g_latency_check
    $fatal(1, "axi_lite_rd_sram: LATENCY=%0d outside 0..15", LATENCY);
  end
  if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_depth_check
    $fatal(1, "axi_lite_rd_sram: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LAT  = 4'b0010,
    ST_READ = 4'b0100,
    ST_RESP = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        ar_ready_q, ar_ready_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic [1:0]  rd_resp_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic [31:0] mem_q [0:DEPTH-1];

  // Misalignment wins over range; addresses below BASE_ADDR wrap to a huge offset.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    if (addr[1:0] != 2'b00) begin
      decode_resp = RESP_SLVERR;
    end else if (off >= SPAN) begin
      decode_resp = RESP_DECERR;
    end else begin
      decode_resp = RESP_OKAY;
    end
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> 32'd2);
  endfunction

  assign ar_hs_s   = slv_ar_valid_i & ar_ready_q;
  assign r_hs_s    = r_valid_q & slv_r_ready_i;
  assign rd_resp_s = decode_resp(addr_q);

  // Next-state and registered-output logic for the IDLE/LAT/READ/RESP sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    ar_ready_d = (state_q == ST_IDLE) && !ar_hs_s;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs_s) begin
          addr_d = slv_ar_addr_i;
          if (LAT_EN) begin
            state_d = ST_LAT;
            cnt_d   = 4'd1;
          end else begin
            state_d = ST_READ;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAT: begin
        if (cnt_q >= LAT_CNT) begin
          state_d = ST_READ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_READ: begin
        state_d   = ST_RESP;
        r_valid_d = 1'b1;
        r_resp_d  = rd_resp_s;
        if (rd_resp_s == RESP_OKAY) begin
          r_data_d = mem_q[word_idx(addr_q)];
        end else begin
          r_data_d = 32'h0000_0000;
        end
      end
      ST_RESP: begin
        if (r_hs_s) begin
          state_d   = ST_IDLE;
          r_valid_d = 1'b0;
          r_data_d  = 32'h0000_0000;
          r_resp_d  = RESP_OKAY;
        end else begin
          state_d   = ST_RESP;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = 4'd0;
        r_valid_d  = 1'b0;
        r_data_d   = 32'h0000_0000;
        r_resp_d   = RESP_OKAY;
        ar_ready_d = 1'b0;
      end
    endcase
  end

  // Control and R-channel registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0000_0000;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= 32'h0000_0000;
      r_resp_q   <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Preload port; a write landing on the READ edge leaves the captured read data old.
  always_ff @(posedge clk_i) begin
    if (ld_en_i && (decode_resp(ld_addr_i) == RESP_OKAY)) begin
      mem_q[word_idx(ld_addr_i)] <= ld_data_i;
    end
  end

  assign slv_ar_ready_o = ar_ready_q;
  assign slv_r_valid_o  = r_valid_q;
  assign slv_r_data_o   = r_data_q;
  assign slv_r_resp_o   = r_resp_q;

endmodule

// File: tb/tb_axi_lite_rd_sram.sv
// Self-checking bench: a LATENCY=2 responder driven by directed and random reads against an
// address-level memory model, plus a LATENCY=0 responder for back-to-back spacing.
module tb_axi_lite_rd_sram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT_A = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_ar_valid, a_ar_ready, a_r_valid, a_r_ready, a_ld_en;
  logic [31:0] a_ar_addr, a_r_data, a_ld_addr, a_ld_data;
  logic [1:0]  a_r_resp;
  logic        b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_ld_en;
  logic [31:0] b_ar_addr, b_r_data, b_ld_addr, b_ld_data;
  logic [1:0]  b_r_resp;

  int errors = 0;
  int checks = 0;
  logic [31:0] mm [int];

  axi_lite_rd_sram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .slv_ar_valid_i(a_ar_valid), .slv_ar_addr_i(a_ar_addr), .slv_ar_ready_o(a_ar_ready),
    .slv_r_valid_o(a_r_valid), .slv_r_data_o(a_r_data), .slv_r_resp_o(a_r_resp),
    .slv_r_ready_i(a_r_ready),
    .ld_en_i(a_ld_en), .ld_addr_i(a_ld_addr), .ld_data_i(a_ld_data)
  );

  axi_lite_rd_sram #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .slv_ar_valid_i(b_ar_valid), .slv_ar_addr_i(b_ar_addr), .slv_ar_ready_o(b_ar_ready),
    .slv_r_valid_o(b_r_valid), .slv_r_data_o(b_r_data), .slv_r_resp_o(b_r_resp),
    .slv_r_ready_i(b_r_ready),
    .ld_en_i(b_ld_en), .ld_addr_i(b_ld_addr), .ld_data_i(b_ld_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // -2: misaligned, -1: outside the window, else word index
  function automatic int model_idx(input logic [31:0] addr);
    longint a, lo;
    a  = longint'(addr);
    lo = longint'(BASE);
    if (a % 64'd4 != 64'd0) return -2;
    if (a < lo || a >= lo + longint'(DEPTH) * 64'd4) return -1;
    return int'((a - lo) / 64'd4);
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    int i;
    i = model_idx(addr);
    if (i == -2) return {2'b10, 32'h0000_0000};
    if (i == -1) return {2'b11, 32'h0000_0000};
    return {2'b00, mm[i]};
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data);
    int i;
    i = model_idx(addr);
    if (i >= 0) mm[i] = data;
  endfunction

  task automatic ld_a(input logic [31:0] addr, input logic [31:0] data);
    a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = data;
    @(posedge clk); #1;
    a_ld_en = 1'b0;
    model_write(addr, data);
  endtask

  // ld_mode 0: none, 1: preload just after the AR handshake, 2: preload in the READ cycle
  task automatic read_a(input logic [31:0] addr, input int hold, input int ld_mode,
                        input logic [31:0] ld_val);
    logic [33:0] exp;
    int k;
    a_ar_valid = 1'b1; a_ar_addr = addr;
    k = 0;
    while (a_ar_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("ar_ready_timeout", 64'(k < 50), 64'd1);
    exp = model_read(addr);
    @(posedge clk); #1;
    a_ar_valid = 1'b0; a_ar_addr = $urandom;
    check("ar_ready_after_hs", 64'(a_ar_ready), 64'd0);
    if (ld_mode == 1) begin
      model_write(addr, ld_val);
      exp = model_read(addr);
    end
    k = 0;
    while (a_r_valid !== 1'b1 && k < 40) begin
      if ((ld_mode == 1 && k == 0) || (ld_mode == 2 && k == LAT_A)) begin
        a_ld_en = 1'b1; a_ld_addr = addr; a_ld_data = ld_val;
      end
      @(posedge clk); #1;
      a_ld_en = 1'b0;
      k++;
      if (a_r_valid !== 1'b1) check("ar_ready_busy", 64'(a_ar_ready), 64'd0);
    end
    check("r_latency", 64'(k), 64'(LAT_A + 1));
    check("r_data", 64'(a_r_data), 64'(exp[31:0]));
    check("r_resp", 64'(a_r_resp), 64'(exp[33:32]));
    if (ld_mode == 2) model_write(addr, ld_val);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(a_r_valid), 64'd1);
      check("hold_data", 64'(a_r_data), 64'(exp[31:0]));
      check("hold_resp", 64'(a_r_resp), 64'(exp[33:32]));
      check("hold_ar_ready", 64'(a_ar_ready), 64'd0);
    end
    a_r_ready = 1'b1;
    @(posedge clk); #1;
    a_r_ready = 1'b0;
    check("r_valid_after_hs", 64'(a_r_valid), 64'd0);
  endtask

  initial begin
    int k, idx, nd, cyc, last_hs, sel;
    logic hs_now, rv_now;
    logic [31:0] addr_b [8];
    logic [31:0] data_b [8];
    logic [31:0] ra;

    rst_n = 1'b0;
    a_ar_valid = 1'b0; a_ar_addr = '0; a_r_ready = 1'b0; a_ld_en = 1'b0; a_ld_addr = '0; a_ld_data = '0;
    b_ar_valid = 1'b0; b_ar_addr = '0; b_r_ready = 1'b0; b_ld_en = 1'b0; b_ld_addr = '0; b_ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_ready", 64'(a_ar_ready), 64'd0);
    check("rst_r_valid", 64'(a_r_valid), 64'd0);
    check("rst_r_data", 64'(a_r_data), 64'd0);
    check("rst_r_resp", 64'(a_r_resp), 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_ar_ready_low", 64'(a_ar_ready), 64'd0);
    @(posedge clk); #1;
    check("release_ar_ready_high", 64'(a_ar_ready), 64'd1);
    check("release_b_ar_ready_high", 64'(b_ar_ready), 64'd1);

    // Directed reads
    ld_a(BASE, 32'h0000_0413);
    for (int i = 1; i < 64; i++) ld_a(BASE + 32'(4 * i), $urandom);
    ld_a(BASE + 32'h0000_3FFC, 32'hCAFE_F00D);
    ld_a(BASE + 32'h0000_0010, 32'h1111_1111);
    read_a(BASE, 0, 0, 32'h0);
    check("plan_mem0_literal", 64'(mm[0]), 64'h0000_0413);
    read_a(32'h8000_0002, 0, 0, 32'h0);
    read_a(32'h7FFF_FFFC, 0, 0, 32'h0);
    read_a(32'h8000_4000, 0, 0, 32'h0);
    read_a(32'h8000_3FFC, 0, 0, 32'h0);
    read_a(BASE, 10, 0, 32'h0);
    ld_a(32'h8000_0001, 32'h5555_AAAA);
    ld_a(32'h8000_4000, 32'h5555_AAAA);
    read_a(BASE, 0, 0, 32'h0);
    read_a(32'h8000_0010, 0, 2, 32'hDEAD_BEEF);
    read_a(32'h8000_0010, 0, 0, 32'h0);
    check("rbw_new_value_model", 64'(mm[4]), 64'hDEAD_BEEF);

    // Random reads, hold times and concurrent preloads
    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 8);
      if (sel <= 5)      ra = BASE + 32'(4 * $urandom_range(0, 63));
      else if (sel == 6) ra = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
      else if (sel == 7) ra = BASE - 32'(4 * $urandom_range(1, 1000));
      else               ra = BASE + 32'h0000_4000 + 32'(4 * $urandom_range(0, 1000));
      read_a(ra, $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    // Reset during the latency phase
    a_ar_valid = 1'b1; a_ar_addr = BASE + 32'd4;
    k = 0;
    while (a_ar_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("rst_mid_ar_wait", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    a_ar_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_r_valid", 64'(a_r_valid), 64'd0);
    check("rst_mid_ar_ready", 64'(a_ar_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_release_ar_ready_low", 64'(a_ar_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_release_ar_ready_high", 64'(a_ar_ready), 64'd1);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_r_valid === 1'b1) k++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_r_beat", 64'(k), 64'd0);
    read_a(BASE + 32'd4, 0, 0, 32'h0);

    // LATENCY=0: back-to-back reads with ar_valid and r_ready held high
    for (int i = 0; i < 8; i++) begin
      addr_b[i] = BASE + 32'(4 * (i * 5 + 3));
      data_b[i] = $urandom;
      b_ld_en = 1'b1; b_ld_addr = addr_b[i]; b_ld_data = data_b[i];
      @(posedge clk); #1;
    end
    b_ld_en = 1'b0;
    b_ar_valid = 1'b1; b_ar_addr = addr_b[0]; b_r_ready = 1'b1;
    idx = 0; nd = 0; cyc = 0; last_hs = 0;
    while ((idx < 8 || nd < 8) && cyc < 200) begin
      hs_now = b_ar_valid && b_ar_ready;
      rv_now = b_r_valid;
      if (rv_now) begin
        if (nd < 8) begin
          check("b_data_order", 64'(b_r_data), 64'(data_b[nd]));
          check("b_resp", 64'(b_r_resp), 64'd0);
        end else begin
          check("b_extra_beat", 64'd1, 64'd0);
        end
        nd++;
      end
      if (hs_now) begin
        if (idx > 0) check("b_ar_spacing", 64'(cyc - last_hs), 64'd4);
        last_hs = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs_now) begin
        idx++;
        if (idx < 8) b_ar_addr = addr_b[idx];
        else b_ar_valid = 1'b0;
      end
    end
    b_r_ready = 1'b0;
    check("b_completed", 64'(cyc < 200), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
